// File: rtl/dma_pkg.sv
// Shared constants for the single-channel DMA engine: register offsets,
// FSM state encodings and STATUS bit positions.
package dma_pkg;

    localparam logic [2:0] REG_START  = 3'd0;
    localparam logic [2:0] REG_CLEAR  = 3'd1;
    localparam logic [2:0] REG_SRC    = 3'd2;
    localparam logic [2:0] REG_DST    = 3'd3;
    localparam logic [2:0] REG_SIZE   = 3'd4;
    localparam logic [2:0] REG_STATUS = 3'd5;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_REQ   = 3'd1;
    localparam logic [2:0] ST_READ  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    localparam int STATUS_DONE_BIT = 0;
    localparam int STATUS_BUSY_BIT = 1;

endpackage

// File: rtl/dma_regfile.sv
// Slave register port of the DMA engine: SRC/DST/SIZE storage (writable only
// while idle), START/CLEAR command pulses and the combinational read mux.
module dma_regfile
    import dma_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int SIZE_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [2:0]        s_addr,
    input  logic [DATA_W-1:0] s_din,
    output logic [DATA_W-1:0] s_dout,
    input  logic              idle,
    input  logic              busy,
    input  logic              done,
    output logic [ADDR_W-1:0] src,
    output logic [ADDR_W-1:0] dst,
    output logic [SIZE_W-1:0] size,
    output logic              start,
    output logic              clear
);

    logic wr_en_s;
    logic unused_din_s;

    assign wr_en_s      = s_sel & s_wr;
    assign start        = wr_en_s & (s_addr == REG_START) & s_din[0];
    assign clear        = wr_en_s & (s_addr == REG_CLEAR) & s_din[0];
    assign unused_din_s = ^s_din[DATA_W-1:ADDR_W];

    // Transfer parameters are frozen while a transfer is in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            src  <= {ADDR_W{1'b0}};
            dst  <= {ADDR_W{1'b0}};
            size <= {SIZE_W{1'b0}};
        end else if (wr_en_s && idle) begin
            case (s_addr)
                REG_SRC:  src  <= s_din[ADDR_W-1:0];
                REG_DST:  dst  <= s_din[ADDR_W-1:0];
                REG_SIZE: size <= s_din[SIZE_W-1:0];
                default:  src  <= src;
            endcase
        end
    end

    // Read mux; unmapped and write-only offsets read as zero.
    always_comb begin
        s_dout = {DATA_W{1'b0}};
        if (s_sel) begin
            case (s_addr)
                REG_SRC:    s_dout = {{(DATA_W-ADDR_W){1'b0}}, src};
                REG_DST:    s_dout = {{(DATA_W-ADDR_W){1'b0}}, dst};
                REG_SIZE:   s_dout = {{(DATA_W-SIZE_W){1'b0}}, size};
                REG_STATUS: begin
                    s_dout[STATUS_BUSY_BIT] = busy;
                    s_dout[STATUS_DONE_BIT] = done;
                end
                default:    s_dout = {DATA_W{1'b0}};
            endcase
        end else begin
            s_dout = {DATA_W{1'b0}};
        end
    end

endmodule

// File: rtl/dma_ctrl.sv
// Single-channel memory-to-memory DMA master: one word per READ/WRITE pair
// while granted, level interrupt on completion until software clears it.
module dma_ctrl
    import dma_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int SIZE_W = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              s_sel,
    input  logic              s_wr,
    input  logic [2:0]        s_addr,
    input  logic [DATA_W-1:0] s_din,
    output logic [DATA_W-1:0] s_dout,
    output logic              m_req,
    input  logic              m_grant,
    output logic [ADDR_W-1:0] m_addr,
    output logic              m_wr,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din,
    output logic              interrupt
);

    logic [2:0]        state_r, state_nx_s;
    logic [SIZE_W-1:0] idx_r, idx_nx_s, idx_inc_s;
    logic [DATA_W-1:0] buf_r, buf_nx_s;
    logic [ADDR_W-1:0] src_s, dst_s, idx_ext_s;
    logic [SIZE_W-1:0] size_s;
    logic              start_s, clear_s, busy_s, idle_s, done_s;

    assign idle_s    = (state_r == ST_IDLE);
    assign done_s    = (state_r == ST_DONE);
    assign busy_s    = (state_r == ST_REQ) | (state_r == ST_READ) | (state_r == ST_WRITE);
    assign idx_inc_s = idx_r + {{(SIZE_W-1){1'b0}}, 1'b1};
    assign idx_ext_s = {{(ADDR_W-SIZE_W){1'b0}}, idx_r};

    dma_regfile #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .SIZE_W (SIZE_W)
    ) u_regfile (
        .clk     (clk),
        .reset_n (reset_n),
        .s_sel   (s_sel),
        .s_wr    (s_wr),
        .s_addr  (s_addr),
        .s_din   (s_din),
        .s_dout  (s_dout),
        .idle    (idle_s),
        .busy    (busy_s),
        .done    (done_s),
        .src     (src_s),
        .dst     (dst_s),
        .size    (size_s),
        .start   (start_s),
        .clear   (clear_s)
    );

    // Next-state logic; a lost grant sends the current word back through REQ.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        buf_nx_s   = buf_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    idx_nx_s   = {SIZE_W{1'b0}};
                    state_nx_s = (size_s != {SIZE_W{1'b0}}) ? ST_REQ : ST_DONE;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_REQ: begin
                if (m_grant) state_nx_s = ST_READ;
                else         state_nx_s = ST_REQ;
            end
            ST_READ: begin
                if (m_grant) begin
                    buf_nx_s   = m_din;
                    state_nx_s = ST_WRITE;
                end else begin
                    state_nx_s = ST_REQ;
                end
            end
            ST_WRITE: begin
                if (m_grant) begin
                    idx_nx_s   = idx_inc_s;
                    state_nx_s = (idx_inc_s == size_s) ? ST_DONE : ST_READ;
                end else begin
                    state_nx_s = ST_REQ;
                end
            end
            ST_DONE: begin
                if (clear_s) state_nx_s = ST_IDLE;
                else         state_nx_s = ST_DONE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM, word index and data buffer.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_IDLE;
            idx_r   <= {SIZE_W{1'b0}};
            buf_r   <= {DATA_W{1'b0}};
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            buf_r   <= buf_nx_s;
        end
    end

    // Bus drive is gated by the grant so an ungranted cycle stays quiet.
    always_comb begin
        m_req     = busy_s;
        interrupt = done_s;
        m_addr    = {ADDR_W{1'b0}};
        m_wr      = 1'b0;
        m_dout    = {DATA_W{1'b0}};
        case (state_r)
            ST_READ: begin
                if (m_grant) m_addr = src_s + idx_ext_s;
                else         m_addr = {ADDR_W{1'b0}};
            end
            ST_WRITE: begin
                if (m_grant) begin
                    m_addr = dst_s + idx_ext_s;
                    m_wr   = 1'b1;
                    m_dout = buf_r;
                end else begin
                    m_wr   = 1'b0;
                end
            end
            default: m_wr = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_dma_ctrl.sv
// Directed bench for dma_ctrl: register-port vector table plus transfer
// sequences against a behavioural memory and registered-grant arbiter.
module tb_dma_ctrl;
    import dma_pkg::*;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        s_sel, s_wr;
    logic [2:0]  s_addr;
    logic [31:0] s_din, s_dout;
    logic        m_req, m_grant, m_wr, interrupt;
    logic [7:0]  m_addr;
    logic [31:0] m_dout, m_din;

    logic [31:0] mem [0:255];
    logic        load_en, drop_active;
    logic [7:0]  load_addr, wr_lo, wr_hi, watch_addr;
    logic [31:0] load_data;
    int          wr_cnt = 0, wr_oor = 0, req_cnt = 0, watch_rd = 0;
    int          checks = 0, failures = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  addr;
        logic [31:0] din;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs [13];

    dma_ctrl #(.ADDR_W(8), .DATA_W(32), .SIZE_W(4)) dut (
        .clk(clk), .reset_n(reset_n), .s_sel(s_sel), .s_wr(s_wr), .s_addr(s_addr),
        .s_din(s_din), .s_dout(s_dout), .m_req(m_req), .m_grant(m_grant),
        .m_addr(m_addr), .m_wr(m_wr), .m_dout(m_dout), .m_din(m_din),
        .interrupt(interrupt)
    );

    always #5 clk = ~clk;

    assign m_din = mem[m_addr];

    // Registered arbiter: grant follows request one cycle later unless blocked.
    always @(posedge clk) begin
        m_grant <= m_req && !drop_active;
    end

    // Memory model and bus statistics.
    always @(posedge clk) begin
        if (load_en) mem[load_addr] <= load_data;
        else if (m_wr) mem[m_addr] <= m_dout;
        if (m_wr) begin
            wr_cnt <= wr_cnt + 1;
            if (m_addr < wr_lo || m_addr > wr_hi) wr_oor <= wr_oor + 1;
        end
        if (m_req) req_cnt <= req_cnt + 1;
        if (m_req && m_grant && !m_wr && m_addr == watch_addr) watch_rd <= watch_rd + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic reg_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        s_sel = 1'b1; s_wr = 1'b1; s_addr = a; s_din = d;
        @(negedge clk);
        s_sel = 1'b0; s_wr = 1'b0; s_din = 32'h0;
    endtask

    task automatic reg_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        s_sel = 1'b1; s_wr = 1'b0; s_addr = a;
        #1;
        d = s_dout;
        s_sel = 1'b0;
    endtask

    task automatic mem_load(input logic [7:0] a, input logic [31:0] d);
        @(negedge clk);
        load_en = 1'b1; load_addr = a; load_data = d;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic wait_irq(output int n);
        n = 0;
        while (!interrupt && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!interrupt) chk("irq_timeout", 32'(interrupt), 32'h1);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        int n, base_wr, base_oor, base_req, base_watch;
        bit dropped, found;

        reset_n = 1'b0; s_sel = 1'b0; s_wr = 1'b0; s_addr = 3'd0; s_din = 32'h0;
        load_en = 1'b0; load_addr = 8'h0; load_data = 32'h0; drop_active = 1'b0;
        wr_lo = 8'h0; wr_hi = 8'hFF; watch_addr = 8'h31;
        repeat (2) @(negedge clk);
        chk("rst_m_req", 32'(m_req), 32'h0);
        chk("rst_m_addr", 32'(m_addr), 32'h0);
        chk("rst_m_wr", 32'(m_wr), 32'h0);
        chk("rst_m_dout", m_dout, 32'h0);
        chk("rst_irq", 32'(interrupt), 32'h0);
        reset_n = 1'b1;

        vecs[0]  = '{1'b0, REG_STATUS, 32'h0, 32'h0};
        vecs[1]  = '{1'b0, REG_SRC,    32'h0, 32'h0};
        vecs[2]  = '{1'b1, REG_SRC,    32'hABCD_EF12, 32'h0};
        vecs[3]  = '{1'b0, REG_SRC,    32'h0, 32'h0000_0012};
        vecs[4]  = '{1'b1, REG_DST,    32'h0000_0134, 32'h0};
        vecs[5]  = '{1'b0, REG_DST,    32'h0, 32'h0000_0034};
        vecs[6]  = '{1'b1, REG_SIZE,   32'h0000_00FF, 32'h0};
        vecs[7]  = '{1'b0, REG_SIZE,   32'h0, 32'h0000_000F};
        vecs[8]  = '{1'b1, 3'd6,       32'h0000_1234, 32'h0};
        vecs[9]  = '{1'b0, 3'd6,       32'h0, 32'h0};
        vecs[10] = '{1'b0, 3'd7,       32'h0, 32'h0};
        vecs[11] = '{1'b0, REG_START,  32'h0, 32'h0};
        vecs[12] = '{1'b0, REG_CLEAR,  32'h0, 32'h0};
        for (int i = 0; i < 13; i++) begin
            if (vecs[i].wr) reg_write(vecs[i].addr, vecs[i].din);
            else begin
                reg_read(vecs[i].addr, rd);
                chk($sformatf("vec%0d", i), rd, vecs[i].exp);
            end
        end
        @(negedge clk);
        s_sel = 1'b0; s_addr = REG_SRC; #1;
        chk("dout_unsel", s_dout, 32'h0);

        // Basic 3-word copy.
        mem_load(8'h10, 32'hAAAA_0001); mem_load(8'h11, 32'hBBBB_0002); mem_load(8'h12, 32'hCCCC_0003);
        for (int i = 0; i < 3; i++) mem_load(8'h40 + 8'(i), 32'h0);
        wr_lo = 8'h40; wr_hi = 8'h42; base_wr = wr_cnt; base_oor = wr_oor;
        reg_write(REG_SRC, 32'h10); reg_write(REG_DST, 32'h40); reg_write(REG_SIZE, 32'h3);
        reg_write(REG_START, 32'h1);
        chk("t1_req_next", 32'(m_req), 32'h1);
        wait_irq(n);
        chk("t1_latency", 32'(n), 32'd8);
        chk("t1_m40", mem[8'h40], 32'hAAAA_0001);
        chk("t1_m41", mem[8'h41], 32'hBBBB_0002);
        chk("t1_m42", mem[8'h42], 32'hCCCC_0003);
        chk("t1_wrcnt", 32'(wr_cnt - base_wr), 32'd3);
        chk("t1_oor", 32'(wr_oor - base_oor), 32'd0);
        chk("t1_req_done", 32'(m_req), 32'h0);
        reg_read(REG_STATUS, rd); chk("t1_status", rd, 32'h1);
        reg_write(REG_CLEAR, 32'h1);
        chk("t1_irq_clr", 32'(interrupt), 32'h0);

        // Zero-length transfer.
        base_req = req_cnt;
        reg_write(REG_SIZE, 32'h0);
        reg_write(REG_START, 32'h1);
        chk("t2_irq", 32'(interrupt), 32'h1);
        reg_read(REG_STATUS, rd); chk("t2_status", rd, 32'h1);
        reg_write(REG_CLEAR, 32'h1);
        chk("t2_irq_clr", 32'(interrupt), 32'h0);
        reg_read(REG_STATUS, rd); chk("t2_status_clr", rd, 32'h0);
        chk("t2_no_req", 32'(req_cnt - base_req), 32'd0);

        // Grant lost during WRITE of word 1.
        for (int i = 0; i < 4; i++) begin
            mem_load(8'h30 + 8'(i), 32'h3000_0000 + 32'(i));
            mem_load(8'h80 + 8'(i), 32'h0);
        end
        wr_lo = 8'h80; wr_hi = 8'h83; watch_addr = 8'h31;
        base_wr = wr_cnt; base_oor = wr_oor; base_watch = watch_rd;
        reg_write(REG_SRC, 32'h30); reg_write(REG_DST, 32'h80); reg_write(REG_SIZE, 32'h4);
        reg_write(REG_START, 32'h1);
        n = 0; dropped = 1'b0;
        while (!interrupt && n < 300) begin
            @(negedge clk);
            n++;
            if (!dropped && m_grant && !m_wr && m_addr == 8'h31) begin
                dropped = 1'b1;
                drop_active = 1'b1;
                repeat (3) @(negedge clk);
                drop_active = 1'b0;
            end
        end
        chk("t3_irq", 32'(interrupt), 32'h1);
        chk("t3_dropped", 32'(dropped), 32'h1);
        for (int i = 0; i < 4; i++)
            chk($sformatf("t3_m%0d", i), mem[8'h80 + 8'(i)], 32'h3000_0000 + 32'(i));
        chk("t3_wrcnt", 32'(wr_cnt - base_wr), 32'd4);
        chk("t3_oor", 32'(wr_oor - base_oor), 32'd0);
        chk("t3_reread", 32'(watch_rd - base_watch), 32'd2);
        reg_write(REG_CLEAR, 32'h1);

        // Source address wraps past 0xFF.
        mem_load(8'hFE, 32'hFE00_00FE); mem_load(8'hFF, 32'hFF00_00FF); mem_load(8'h00, 32'h0000_5A5A);
        for (int i = 0; i < 3; i++) mem_load(8'h20 + 8'(i), 32'h0);
        wr_lo = 8'h20; wr_hi = 8'h22; base_wr = wr_cnt; base_oor = wr_oor;
        reg_write(REG_SRC, 32'hFE); reg_write(REG_DST, 32'h20); reg_write(REG_SIZE, 32'h3);
        reg_write(REG_START, 32'h1);
        wait_irq(n);
        chk("t4_m20", mem[8'h20], 32'hFE00_00FE);
        chk("t4_m21", mem[8'h21], 32'hFF00_00FF);
        chk("t4_m22", mem[8'h22], 32'h0000_5A5A);
        chk("t4_oor", 32'(wr_oor - base_oor), 32'd0);
        reg_write(REG_CLEAR, 32'h1);

        // Register writes, START and CLEAR while busy are ignored.
        for (int i = 0; i < 3; i++) mem_load(8'h70 + 8'(i), 32'h0);
        wr_lo = 8'h70; wr_hi = 8'h72; base_wr = wr_cnt; base_oor = wr_oor;
        reg_write(REG_SRC, 32'h10); reg_write(REG_DST, 32'h70); reg_write(REG_SIZE, 32'h3);
        reg_write(REG_START, 32'h1);
        reg_write(REG_SRC, 32'h55);
        reg_read(REG_STATUS, rd); chk("t5_status_busy", rd, 32'h2);
        reg_write(REG_START, 32'h1);
        reg_write(REG_CLEAR, 32'h1);
        reg_read(REG_SRC, rd); chk("t5_src_kept", rd, 32'h10);
        wait_irq(n);
        chk("t5_m70", mem[8'h70], 32'hAAAA_0001);
        chk("t5_m71", mem[8'h71], 32'hBBBB_0002);
        chk("t5_m72", mem[8'h72], 32'hCCCC_0003);
        chk("t5_wrcnt", 32'(wr_cnt - base_wr), 32'd3);
        chk("t5_oor", 32'(wr_oor - base_oor), 32'd0);
        reg_write(REG_CLEAR, 32'h1);

        // Reset asserted during READ of word 2.
        for (int i = 0; i < 4; i++) begin
            mem_load(8'h50 + 8'(i), 32'h5000_0000 + 32'(i));
            mem_load(8'h60 + 8'(i), 32'h0);
        end
        reg_write(REG_SRC, 32'h50); reg_write(REG_DST, 32'h60); reg_write(REG_SIZE, 32'h4);
        reg_write(REG_START, 32'h1);
        n = 0; found = 1'b0;
        while (!found && n < 100) begin
            @(negedge clk);
            n++;
            if (m_grant && !m_wr && m_addr == 8'h52) found = 1'b1;
        end
        chk("t6_found_read2", 32'(found), 32'h1);
        reset_n = 1'b0;
        #1;
        chk("t6_m_req", 32'(m_req), 32'h0);
        chk("t6_m_addr", 32'(m_addr), 32'h0);
        chk("t6_m_wr", 32'(m_wr), 32'h0);
        chk("t6_m_dout", m_dout, 32'h0);
        chk("t6_irq", 32'(interrupt), 32'h0);
        @(negedge clk);
        reset_n = 1'b1;
        reg_read(REG_SRC, rd);    chk("t6_src", rd, 32'h0);
        reg_read(REG_DST, rd);    chk("t6_dst", rd, 32'h0);
        reg_read(REG_SIZE, rd);   chk("t6_size", rd, 32'h0);
        reg_read(REG_STATUS, rd); chk("t6_status", rd, 32'h0);
        chk("t6_m61", mem[8'h61], 32'h5000_0001);
        chk("t6_m62", mem[8'h62], 32'h0);
        repeat (3) @(negedge clk);
        chk("t6_irq_after", 32'(interrupt), 32'h0);
        chk("t6_req_after", 32'(m_req), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dma_ctrl.md
# dma_ctrl

Single-channel DMA engine acting as bus master m1 on the shared system bus; it competes with the CPU (m0) through the two-master bus arbiter by driving `m_req` and consuming `m_grant`. Software programs source, destination and word count through a small slave register port, writes START, and the engine copies words memory-to-memory, raising `interrupt` when done. One word moves per read/write cycle pair while it holds the grant.

## Interface
- `ADDR_W`, 8, bus address width (word addresses)
- `DATA_W`, 32, bus data width
- `SIZE_W`, 4, width of word-count register (max 15 words)
- `clk`  in  1  clock; all state changes on rising edge
- `reset_n`  in  1  reset, asynchronous, active-low
- `s_sel`  in  1  slave register access this cycle
- `s_wr`  in  1  1 = write, 0 = read (valid with `s_sel`)
- `s_addr`  in  3  register offset
- `s_din`  in  DATA_W  slave write data
- `s_dout`  out  DATA_W  slave read data, combinational from `s_addr`; 0 when `s_sel`=0
- `m_req`  out  1  bus request to arbiter (m1_req)
- `m_grant`  in  1  bus grant from arbiter (m1_grant)
- `m_addr`  out  ADDR_W  master address; 0 when not granted
- `m_wr`  out  1  master write strobe
- `m_dout`  out  DATA_W  master write data
- `m_din`  in  DATA_W  master read data, valid same cycle as `m_addr`
- `interrupt`  out  1  transfer complete, level, held until cleared

## Operation
- Register map: 0 START (write, bit0=1 starts), 1 CLEAR (write, bit0=1 clears done), 2 SRC (rw), 3 DST (rw), 4 SIZE (rw), 5 STATUS (ro: bit1 busy, bit0 done). Other offsets read 0, writes ignored.
- SRC/DST/SIZE writes accepted only in IDLE; ignored otherwise. SIZE takes low SIZE_W bits.
- States: IDLE, REQ, READ, WRITE, DONE.
- IDLE: START with SIZE≠0 -> REQ, word index i=0. START with SIZE=0 -> DONE directly, no bus request.
- REQ: `m_req`=1; on `m_grant`=1 -> READ.
- READ: `m_req`=1, `m_addr`=SRC+i, `m_wr`=0; `m_din` latched into data buffer at clock edge -> WRITE.
- WRITE: `m_req`=1, `m_addr`=DST+i, `m_wr`=1, `m_dout`=buffer; i increments; if i+1==SIZE -> DONE else -> READ.
- Grant lost (`m_grant`=0) in READ or WRITE: no bus drive that cycle, i unchanged, -> REQ; the current word restarts from READ.
- DONE: `m_req`=0, `interrupt`=1, STATUS.done=1; CLEAR -> IDLE and `interrupt`=0. CLEAR in other states ignored. START outside IDLE ignored.
- Address arithmetic modulo 2^ADDR_W (SRC+i wraps, no error).
- busy = state in {REQ, READ, WRITE}.

## Timing
- Reset: state IDLE; SRC, DST, SIZE, buffer, i = 0; `m_req`, `m_wr`, `interrupt` = 0; `m_addr`, `m_dout` = 0.
- Reset mid-transfer aborts immediately; no partial-word completion, no interrupt.
- START at edge t -> `m_req`=1 in cycle t+1.
- Arbiter grant is registered: `m_grant` rises ≥1 cycle after `m_req`; READ begins cycle after grant seen.
- Steady state: 2 cycles per word; N words take 2N cycles from first READ to DONE.
- `m_req` stays high from REQ through last WRITE (back-to-back words keep the bus); drops in the DONE cycle.
- `interrupt` rises cycle after last WRITE; falls cycle after CLEAR.

## Structure
- Package `dma_pkg`: register offset constants, state enum (IDLE, REQ, READ, WRITE, DONE), STATUS bit positions.
- Sub-module `dma_regfile`: slave decode, SRC/DST/SIZE storage with IDLE-only write enable, START/CLEAR pulse outputs, STATUS read mux. FSM, index counter and data buffer in top `dma_ctrl`.

## Test plan
- SRC=0x10, DST=0x40, SIZE=3, memory[0x10..0x12]=A,B,C, grant 1 cycle after req -> memory[0x40..0x42]=A,B,C, 6 transfer cycles, `interrupt`=1, STATUS=0x1.
- SIZE=0 + START -> DONE next cycle, `m_req` never asserted, `interrupt`=1; CLEAR -> `interrupt`=0, STATUS=0.
- SIZE=4, drop `m_grant` during WRITE of word 1 for 3 cycles -> word 1 re-read then written; final 4 words correct, none duplicated at wrong address.
- SRC=0xFE, DST=0x20, SIZE=3 -> reads 0xFE, 0xFF, 0x00; writes 0x20..0x22.
- Write SRC=0x55 and START while busy -> SRC unchanged, transfer unaffected; CLEAR while busy ignored.
- Assert reset_n=0 during READ of word 2 -> all outputs 0 same cycle, state IDLE, registers 0, no interrupt.
